// File: rtl/io_intr_unit_if.sv
// io_intr_unit_if: CPU-side I/O bus and interrupt handshake for io_intr_unit
//   io_cs/io_rd/io_wr  chip select and strobes
//   io_address         byte address
//   io_d_in            write data
//   intr               interrupt request to the CPU
//   inta               interrupt acknowledge from the CPU
interface io_intr_unit_if #(
    parameter int DATA_W = 32
);
    logic              io_cs;
    logic              io_rd;
    logic              io_wr;
    logic [31:0]       io_address;
    logic [DATA_W-1:0] io_d_in;
    logic              intr;
    logic              inta;
    modport master (output io_cs, io_rd, io_wr, io_address, io_d_in, inta, input intr);
    modport slave  (input io_cs, io_rd, io_wr, io_address, io_d_in, inta, output intr);
endinterface

// File: rtl/io_intr_unit.sv
// io_intr_unit: scratch RAM, interrupt CSR bank and intr/inta handshake FSM
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   irq_src  raw interrupt request lines, synchronous to clk
//   bus      I/O bus strobes, address, write data and intr/inta handshake
//   io_out   read data, high-Z unless io_cs & io_rd (kept at the block boundary
//            so the tri-state driver is a plain module output)
module io_intr_unit #(
    parameter int          NUM_CH   = 4,
    parameter int          DATA_W   = 32,
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] CSR_BASE = 32'hFF0,
    parameter int          ACK_TO   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] irq_src,
    io_intr_unit_if.slave     bus,
    output wire  [DATA_W-1:0] io_out
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, ACK} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NUM_CH-1:0] enable, pending, mode, src_q, pend_n, qual, w1c, ack_clr;
    logic              vec_valid, inta_q, intr_q, is_csr, wr, ack_ev;
    logic [4:0]        vec_id, win;
    logic [31:0]       cnt, off;
    logic [DATA_W-1:0] rdata, vec_word;

    assign is_csr  = bus.io_address >= CSR_BASE;
    assign off     = bus.io_address - CSR_BASE;
    assign wr      = bus.io_cs & bus.io_wr;
    assign qual    = pending & enable;
    // an acknowledge only counts while a qualifying request still exists
    assign ack_ev  = (state == REQ) && bus.inta && !inta_q && (|qual);
    assign ack_clr = ack_ev ? (NUM_CH'(1) << win) : '0;
    assign w1c     = (wr && is_csr && off == 32'h4) ? bus.io_d_in[NUM_CH-1:0] : '0;
    // edge channels: a fresh rising edge beats W1C/ack clears in the same cycle
    assign pend_n  = (mode & ((irq_src & ~src_q) | (pending & ~w1c & ~ack_clr)))
                   | (~mode & irq_src);
    assign bus.intr = intr_q;
    assign io_out   = (bus.io_cs && bus.io_rd) ? rdata : 'z;

    always_comb begin
        win = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (qual[i]) win = 5'(i);
    end

    always_comb begin
        vec_word      = '0;
        vec_word[31]  = vec_valid;
        vec_word[4:0] = vec_id;
        rdata = !is_csr       ? mem[bus.io_address[AW+1:2]] :
                off == 32'h0  ? DATA_W'(enable)  :
                off == 32'h4  ? DATA_W'(pending) :
                off == 32'h8  ? DATA_W'(mode)    :
                off == 32'hC  ? vec_word         : '0;
    end

    always_ff @(posedge clk)
        if (wr && !is_csr) mem[bus.io_address[AW+1:2]] <= bus.io_d_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            intr_q    <= 1'b0;
            enable    <= '0;
            pending   <= '0;
            mode      <= '0;
            src_q     <= '0;
            inta_q    <= 1'b0;
            vec_valid <= 1'b0;
            vec_id    <= '0;
            cnt       <= '0;
        end else begin
            src_q   <= irq_src;
            inta_q  <= bus.inta;
            pending <= pend_n;
            if (wr && is_csr && off == 32'h0) enable <= bus.io_d_in[NUM_CH-1:0];
            if (wr && is_csr && off == 32'h8) mode   <= bus.io_d_in[NUM_CH-1:0];
            case (state)
                IDLE: if (|qual) begin
                    state  <= REQ;
                    intr_q <= 1'b1;
                    cnt    <= '0;
                end
                REQ: begin
                    if (ack_ev) begin
                        vec_valid <= 1'b1;
                        vec_id    <= win;
                        state     <= ACK;
                        intr_q    <= 1'b0;
                    end else if (!(|qual)) begin
                        state  <= IDLE;
                        intr_q <= 1'b0;
                    end else if (ACK_TO != 0 && cnt == 32'(ACK_TO - 1)) begin
                        state  <= IDLE;
                        intr_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1;
                    end
                end
                ACK: if (!bus.inta) state <= IDLE;
                default: begin
                    state  <= IDLE;
                    intr_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
